// File: rtl/stream_demux16_pkg.sv
// Shared defaults and slot-state type for the 1-to-2 stream demultiplexer.
package stream_demux16_pkg;

  localparam int unsigned DefaultDw = 16;
  localparam int unsigned DefaultCw = 8;

  typedef enum logic {
    SlotEmpty = 1'b0,
    SlotFull  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/stream_demux16_if.sv
// Handshake bundle for stream_demux16: one input stream, two output slots, counters.
interface stream_demux16_if
  import stream_demux16_pkg::*;
#(
  parameter int unsigned DW = DefaultDw,
  parameter int unsigned CW = DefaultCw
) ();

  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          sel;
  logic          out0_valid;
  logic          out0_ready;
  logic [DW-1:0] out0_data;
  logic          out1_valid;
  logic          out1_ready;
  logic [DW-1:0] out1_data;
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;

  // Demux side.
  modport slave (
    input  flush, in_valid, in_data, sel, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
  );

  // Producer / consumer side.
  modport master (
    output flush, in_valid, in_data, sel, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
  );

endinterface

// File: rtl/demux_slot.sv
// Single output slot: EMPTY/FULL state, data register and accept counter.
module demux_slot
  import stream_demux16_pkg::*;
#(
  parameter int unsigned DW = DefaultDw,
  parameter int unsigned CW = DefaultCw
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          load_i,
  input  logic [DW-1:0] load_data_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic [CW-1:0] cnt_o
);

  slot_state_e   state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next state: flush wins, a load always fills, a drain without load empties.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = SlotEmpty;
    end else if (load_i) begin
      state_d = SlotFull;
      data_d  = load_data_i;
      cnt_d   = cnt_q + CW'(1);
    end else if (state_q == SlotFull && ready_i) begin
      state_d = SlotEmpty;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SlotEmpty;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid_o = (state_q == SlotFull);
  assign data_o  = data_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/stream_demux16.sv
// Steers an input stream into one of two single-word output slots by sel.
module stream_demux16
  import stream_demux16_pkg::*;
#(
  parameter int unsigned DW = DefaultDw,
  parameter int unsigned CW = DefaultCw
) (
  input  logic              clk,
  input  logic              rst,
  stream_demux16_if.slave   bus
);

  logic in_ready;
  logic accept;
  logic load0;
  logic load1;

  // Selected slot can take a word if empty or draining this cycle; rst gates it so
  // in_ready reads low for the whole reset, not just after the first edge.
  always_comb begin
    in_ready = 1'b0;
    if (!rst && !bus.flush) begin
      if (bus.sel) begin
        in_ready = !bus.out1_valid || bus.out1_ready;
      end else begin
        in_ready = !bus.out0_valid || bus.out0_ready;
      end
    end
  end

  assign accept       = bus.in_valid && in_ready;
  assign load0        = accept && !bus.sel;
  assign load1        = accept && bus.sel;
  assign bus.in_ready = in_ready;

  demux_slot #(
    .DW (DW),
    .CW (CW)
  ) u_slot0 (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (bus.flush),
    .load_i      (load0),
    .load_data_i (bus.in_data),
    .ready_i     (bus.out0_ready),
    .valid_o     (bus.out0_valid),
    .data_o      (bus.out0_data),
    .cnt_o       (bus.cnt0)
  );

  demux_slot #(
    .DW (DW),
    .CW (CW)
  ) u_slot1 (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (bus.flush),
    .load_i      (load1),
    .load_data_i (bus.in_data),
    .ready_i     (bus.out1_ready),
    .valid_o     (bus.out1_valid),
    .data_o      (bus.out1_data),
    .cnt_o       (bus.cnt1)
  );

endmodule

// File: tb/tb_stream_demux16.sv
// Self-checking bench for stream_demux16: scoreboard queues per channel plus directed checks.
module tb_stream_demux16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  stream_demux16_if #(.DW(16), .CW(8)) bus ();

  stream_demux16 #(
    .DW (16),
    .CW (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: slot occupancy, counters and expected slot words.
  logic        mf0, mf1;
  logic [7:0]  mc0, mc1;
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic        exp_rdy;
  logic        acc;

  // Sample away from the active edge and advance the model to the next edge.
  always @(negedge clk) begin
    if (rst) begin
      check_eq("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
      check_eq("rst_out0_valid", {31'b0, bus.out0_valid}, 32'd0);
      check_eq("rst_out1_valid", {31'b0, bus.out1_valid}, 32'd0);
      check_eq("rst_out0_data", {16'b0, bus.out0_data}, 32'd0);
      check_eq("rst_out1_data", {16'b0, bus.out1_data}, 32'd0);
      check_eq("rst_cnt0", {24'b0, bus.cnt0}, 32'd0);
      check_eq("rst_cnt1", {24'b0, bus.cnt1}, 32'd0);
      mf0 = 1'b0;
      mf1 = 1'b0;
      mc0 = '0;
      mc1 = '0;
      q0.delete();
      q1.delete();
    end else begin
      exp_rdy = !bus.flush && (bus.sel ? (!mf1 || bus.out1_ready) : (!mf0 || bus.out0_ready));
      check_eq("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_rdy});
      check_eq("out0_valid", {31'b0, bus.out0_valid}, {31'b0, mf0});
      check_eq("out1_valid", {31'b0, bus.out1_valid}, {31'b0, mf1});
      if (mf0 && q0.size() > 0) check_eq("out0_data", {16'b0, bus.out0_data}, {16'b0, q0[0]});
      if (mf1 && q1.size() > 0) check_eq("out1_data", {16'b0, bus.out1_data}, {16'b0, q1[0]});
      check_eq("cnt0", {24'b0, bus.cnt0}, {24'b0, mc0});
      check_eq("cnt1", {24'b0, bus.cnt1}, {24'b0, mc1});
      acc = bus.in_valid && exp_rdy;
      if (bus.flush) begin
        mf0 = 1'b0;
        mf1 = 1'b0;
        q0.delete();
        q1.delete();
      end else begin
        if (mf0 && bus.out0_ready) begin
          void'(q0.pop_front());
          mf0 = 1'b0;
        end
        if (mf1 && bus.out1_ready) begin
          void'(q1.pop_front());
          mf1 = 1'b0;
        end
        if (acc && !bus.sel) begin
          q0.push_back(bus.in_data);
          mf0 = 1'b1;
          mc0 = mc0 + 8'd1;
        end
        if (acc && bus.sel) begin
          q1.push_back(bus.in_data);
          mf1 = 1'b1;
          mc1 = mc1 + 8'd1;
        end
      end
    end
  end

  // Drive one cycle of stimulus at posedge+1 and advance to the next posedge+1.
  task automatic cyc(input logic v, input logic s, input logic [15:0] d,
                     input logic r0, input logic r1, input logic fl);
    bus.in_valid   = v;
    bus.sel        = s;
    bus.in_data    = d;
    bus.out0_ready = r0;
    bus.out1_ready = r1;
    bus.flush      = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.sel        = 1'b0;
    bus.in_data    = '0;
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    bus.flush      = 1'b0;
    #1 rst = 1'b1;
    #2;
    check_eq("por_out0_valid", {31'b0, bus.out0_valid}, 32'd0);
    check_eq("por_in_ready", {31'b0, bus.in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic accept into channel 0.
    cyc(1'b1, 1'b0, 16'hA5A5, 1'b1, 1'b1, 1'b0);
    check_eq("s1_out0_valid", {31'b0, bus.out0_valid}, 32'd1);
    check_eq("s1_out0_data", {16'b0, bus.out0_data}, 32'hA5A5);
    check_eq("s1_out1_valid", {31'b0, bus.out1_valid}, 32'd0);
    check_eq("s1_cnt0", {24'b0, bus.cnt0}, 32'd1);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);

    // Backpressure on channel 1.
    cyc(1'b1, 1'b1, 16'h1111, 1'b1, 1'b0, 1'b0);
    bus.in_data = 16'h2222;
    #1;
    check_eq("s2_blocked", {31'b0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    cyc(1'b1, 1'b1, 16'h2222, 1'b1, 1'b0, 1'b0);
    check_eq("s2_hold", {16'b0, bus.out1_data}, 32'h1111);
    cyc(1'b1, 1'b1, 16'h2222, 1'b1, 1'b1, 1'b0);
    check_eq("s2_new", {16'b0, bus.out1_data}, 32'h2222);
    check_eq("s2_cnt1", {24'b0, bus.cnt1}, 32'd2);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);

    // Load while draining keeps slot 0 full without a bubble.
    cyc(1'b1, 1'b0, 16'h1234, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 16'h3333, 1'b1, 1'b1, 1'b0);
    check_eq("s3_valid", {31'b0, bus.out0_valid}, 32'd1);
    check_eq("s3_data", {16'b0, bus.out0_data}, 32'h3333);
    check_eq("s3_cnt0", {24'b0, bus.cnt0}, 32'd3);

    // Flush with both slots full.
    cyc(1'b1, 1'b1, 16'h4444, 1'b0, 1'b0, 1'b0);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.sel      = 1'b0;
    bus.in_data  = 16'h5555;
    #1;
    check_eq("s4_in_ready", {31'b0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("s4_v0", {31'b0, bus.out0_valid}, 32'd0);
    check_eq("s4_v1", {31'b0, bus.out1_valid}, 32'd0);
    check_eq("s4_cnt0", {24'b0, bus.cnt0}, 32'd3);
    check_eq("s4_cnt1", {24'b0, bus.cnt1}, 32'd3);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);

    // Counter wrap after a fresh reset.
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      cyc(1'b1, 1'b0, 16'(i * 7 + 1), 1'b1, 1'b1, 1'b0);
    end
    check_eq("s5_cnt0_wrap", {24'b0, bus.cnt0}, 32'd0);
    check_eq("s5_cnt1", {24'b0, bus.cnt1}, 32'd0);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset while slot 1 is full.
    cyc(1'b1, 1'b1, 16'h7777, 1'b1, 1'b0, 1'b0);
    check_eq("s6_pre_valid", {31'b0, bus.out1_valid}, 32'd1);
    check_eq("s6_pre_cnt1", {24'b0, bus.cnt1}, 32'd1);
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("s6_async_valid", {31'b0, bus.out1_valid}, 32'd0);
    check_eq("s6_async_cnt1", {24'b0, bus.cnt1}, 32'd0);
    check_eq("s6_async_rdy", {31'b0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1'b1, 1'b1, 16'h8888, 1'b1, 1'b0, 1'b0);
    check_eq("s6_post_valid", {31'b0, bus.out1_valid}, 32'd1);
    check_eq("s6_post_data", {16'b0, bus.out1_data}, 32'h8888);
    check_eq("s6_post_cnt1", {24'b0, bus.cnt1}, 32'd1);

    // Mixed traffic to exercise the scoreboard.
    for (int i = 0; i < 200; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end
    repeat (3) cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stream_demux16.md
STREAM_DEMUX16 -- requirements
Module: stream_demux16

Interface
REQ-001 Parameter DW, default 16: data width of the input and of each output channel.
REQ-002 Parameter CW, default 8: width of each per-channel transfer counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  synchronous clear of both output slots.
REQ-006 in_valid  input  1  input word present.
REQ-007 in_ready  output  1  input word accepted this cycle when high together with in_valid.
REQ-008 in_data  input  DW  input word.
REQ-009 sel  input  1  destination of the input word: 0 -> channel 0, 1 -> channel 1; sampled only with in_valid.
REQ-010 out0_valid, out1_valid  output  1 each  slot holds a word.
REQ-011 out0_ready, out1_ready  input  1 each  downstream accepts the slot word.
REQ-012 out0_data, out1_data  output  DW each  slot word.
REQ-013 cnt0, cnt1  output  CW each  count of words accepted into each channel.

Function
REQ-014 Each channel has one slot with states EMPTY (valid 0) and FULL (valid 1).
REQ-015 in_ready = !flush && (slot[sel] EMPTY || outN_ready of slot[sel]); combinational from sel, flush, slot state and the selected outN_ready.
REQ-016 Accept = in_valid && in_ready; on accept, in_data loads into slot[sel] at the next edge and that slot becomes FULL (latency 1 cycle).
REQ-017 The non-selected channel is never written and its data stays unchanged.
REQ-018 A FULL slot with outN_ready high and no load into it becomes EMPTY at the next edge.
REQ-019 A FULL slot with outN_ready high and a load in the same cycle takes the new word and stays FULL; no bubble.
REQ-020 outN_data holds its value while FULL and outN_ready is low; it changes only on a load.
REQ-021 EMPTY slot outN_data: value is don't-care, but it is not reset to X after reset; it is reset to 0.
REQ-022 flush high: both slots become EMPTY at the next edge; in_ready is 0; no accept occurs; counters hold.
REQ-023 cntN increments by 1 on each accept into channel N and wraps from 2^CW-1 to 0.
REQ-024 Drains never change a counter; simultaneous accept and drain on one channel increments its counter once.
REQ-025 in_valid low: the block ignores sel and in_data.

Reset
REQ-026 While rst is high: out0_valid = out1_valid = 0, out0_data = out1_data = 0, cnt0 = cnt1 = 0, in_ready = 0; effect is immediate, without waiting for a clock edge.
REQ-027 Reset mid-transfer discards slot contents; the first accept is possible in the first cycle after rst deasserts.

Structure
REQ-028 Shared package holds the DW and CW defaults and the EMPTY/FULL slot-state enum.
REQ-029 One sub-module, demux_slot (one slot with its state, data register and counter), instantiated twice; steering and in_ready logic live in the top module.

Verification
REQ-030 Scenario: reset, then sel=0, in_data=16'hA5A5, both outN_ready=1 -> out0_valid=1, out0_data=A5A5 one cycle later; out1_valid=0; cnt0=1.
REQ-031 Scenario: out1_ready=0, two words to sel=1 (1111, 2222) -> first word accepted; in_ready=0 on the second; out1_data stays 1111 until out1_ready=1; then 2222 is accepted and cnt1=2.
REQ-032 Scenario: slot 0 FULL, out0_ready=1, new word 3333 to sel=0 in the same cycle -> out0_valid stays 1, out0_data=3333 next cycle, cnt0 increments once.
REQ-033 Scenario: both slots FULL, flush=1 with in_valid=1 -> in_ready=0; both valids 0 next cycle; counters unchanged.
REQ-034 Scenario: 256 accepts to channel 0 with CW=8 -> cnt0 returns to 0; cnt1 remains 0.
REQ-035 Scenario: rst asserted between edges while slot 1 is FULL -> out1_valid=0 and cnt1=0 immediately; first accept succeeds in the first cycle after release.
